vp_psum_accumulator: RTL and testbench
======================================

// Module: vp_psum_accumulator
// PURPOSE
//  Downstream consumer of the VP encoder's left/right ping-pong operand buffers.
//  Each accepted buffer carries up to LANES (ia, w, output-address) triples.
//  Per triple: multiply ia*w and accumulate into a partial-sum bank indexed by output address.
//  On flush, streams the whole bank out with a valid/ready handshake and clears it.
// PARAMETERS
//  LANES   3   operand triples per buffer
//  DATA_W  16  signed width of ia and w
//  ADDR_W  7   output-address width; bank depth = 2**ADDR_W
//  ACC_W   40  signed accumulator width (saturating)
// PORTS
//  i_clk            in   1               clock, rising edge
//  i_rst_n          in   1               async active-low reset
//  i_left_ready     in   1               left buffer holds valid data
//  i_left_lane_vld  in   LANES           per-lane valid, left buffer
//  i_left_addr      in   LANES*ADDR_W    output address per lane, left
//  i_left_w         in   LANES*DATA_W    signed weight per lane, left
//  i_left_ia        in   LANES*DATA_W    signed activation per lane, left
//  o_left_ack       out  1               1-cycle pulse: left buffer consumed
//  i_right_*        in   (as left)       right buffer, same fields
//  o_right_ack      out  1               1-cycle pulse: right buffer consumed
//  i_flush          in   1               request drain of the partial-sum bank
//  o_busy           out  1               FSM not in IDLE
//  o_psum_valid     out  1               drain beat valid
//  i_psum_ready     in   1               downstream accepts drain beat
//  o_psum_addr      out  ADDR_W          bank address of drain beat
//  o_psum_data      out  ACC_W           signed partial sum of drain beat
//  o_done           out  1               1-cycle pulse after last drain beat
// BEHAVIOUR
//  Reset: all outputs 0; bank cleared to 0; ping-pong pointer = LEFT; FSM = IDLE.
//  FSM states: IDLE, ACCUM, FLUSH_WAIT, DRAIN.
//   IDLE->ACCUM when the pointed buffer's ready is 1.
//   IDLE/ACCUM->FLUSH_WAIT when i_flush=1 (flush takes priority; no ack that cycle).
//   FLUSH_WAIT: 2 cycles for the pipeline to empty, then ->DRAIN.
//   DRAIN->IDLE after the beat at address 2**ADDR_W-1 handshakes; o_done pulses next cycle.
//  Consume:
//   - In IDLE/ACCUM, if the pointed buffer is ready: latch its lanes, pulse its ack the same cycle, toggle pointer.
//   - A ready on the non-pointed buffer waits; never two acks in one cycle.
//   - Max 1 buffer/cycle.
//   - ACCUM->IDLE when the pointed buffer is not ready and the pipeline is empty.
//  Pipeline (capture at edge C):
//   - C+1: products registered; DATA_W*2 bits, signed.
//   - C+2: bank updated.
//   - Total latency 2 cycles.
//  Combining:
//   - Valid lanes sharing an address in one buffer are summed before the bank write.
//   - Result equals sequential accumulation.
//   - Lanes with vld=0 contribute nothing.
//   - A write at C+2 is visible to the read for a buffer captured at C+1 (forwarding); back-to-back same-address updates are never lost.
//  Arithmetic: bank += sum of products, saturating to [-2**(ACC_W-1), 2**(ACC_W-1)-1]; a saturated entry stays clamped until drained.
//  Drain:
//   - Beats for addr 0..2**ADDR_W-1 ascending, zero entries included.
//   - o_psum_addr/o_psum_data are held stable while valid && !ready.
//   - On handshake, the entry is cleared to 0 and the address increments.
//   - o_psum_valid deasserts after the last beat.
//   - i_flush is ignored while in FLUSH_WAIT/DRAIN.
//   - Both acks are held 0 in FLUSH_WAIT/DRAIN.
//  Reset mid-operation (any state): immediate return to reset values; in-flight products discarded.
// TESTING
//  1. Left ready, lanes {a5:3*4, a6:-2*7, a7:100*100}, then flush -> o_left_ack 1 cycle; drain addr5=12, addr6=-14, addr7=10000, all other addrs 0; o_done after 128 beats.
//  2. Left and right ready together -> left ack at cycle N, right ack at N+1; right-only at reset -> no ack until left becomes ready.
//  3. All 3 lanes addr 9 (2*3, 4*5, -1*1), then next buffer addr 9 (10*10) back-to-back -> drain addr9=125.
//  4. Accumulate 32767*32767 into addr 0 repeatedly until past 2**39-1 -> drain addr0 = 2**39-1 (saturated, no wrap); negative case saturates to -2**39.
//  5. Drain with i_psum_ready toggling 1,0,0,1 -> addr/data held during stalls; second flush after done -> all 128 beats are 0.
//  6. Assert i_rst_n=0 mid-DRAIN at addr 40 -> outputs 0 at once; flush after reset -> all entries 0.

Source files
------------

// File: rtl/vp_psum_accumulator.sv
// Partial-sum accumulator fed by the VP encoder's left/right ping-pong operand buffers.
// Products are accumulated per output address in a saturating bank, then streamed out on flush.
module vp_psum_accumulator #(
  parameter int unsigned LANES  = 3,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned ACC_W  = 40
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_left_ready,
  input  logic [LANES-1:0]          i_left_lane_vld,
  input  logic [LANES*ADDR_W-1:0]   i_left_addr,
  input  logic [LANES*DATA_W-1:0]   i_left_w,
  input  logic [LANES*DATA_W-1:0]   i_left_ia,
  output logic                      o_left_ack,
  input  logic                      i_right_ready,
  input  logic [LANES-1:0]          i_right_lane_vld,
  input  logic [LANES*ADDR_W-1:0]   i_right_addr,
  input  logic [LANES*DATA_W-1:0]   i_right_w,
  input  logic [LANES*DATA_W-1:0]   i_right_ia,
  output logic                      o_right_ack,
  input  logic                      i_flush,
  output logic                      o_busy,
  output logic                      o_psum_valid,
  input  logic                      i_psum_ready,
  output logic [ADDR_W-1:0]         o_psum_addr,
  output logic [ACC_W-1:0]          o_psum_data,
  output logic                      o_done
);

  localparam int unsigned DEPTH  = 2**ADDR_W;
  localparam int unsigned PROD_W = 2*DATA_W;
  localparam int unsigned WIDE_W = ACC_W + 2;
  localparam logic signed [WIDE_W-1:0] ACC_MAX =
      {{(WIDE_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [WIDE_W-1:0] ACC_MIN = ~ACC_MAX;

  typedef enum logic [1:0] {StIdle, StAccum, StFlushWait, StDrain} state_e;

  state_e state_q, state_d;
  logic   ptr_q;
  logic   fw_cnt_q;
  logic   done_q;
  logic [ADDR_W-1:0] drain_addr_q;

  logic [LANES-1:0]              s0_vld_q, s1_vld_q;
  logic [LANES-1:0][ADDR_W-1:0]  s0_addr_q, s1_addr_q;
  logic [LANES-1:0][DATA_W-1:0]  s0_ia_q, s0_w_q;
  logic [LANES-1:0][PROD_W-1:0]  s1_prod_q;
  logic signed [ACC_W-1:0]       bank_q [DEPTH];

  logic sel_ready, consume, pipe_empty, drain_hs, drain_last;
  logic signed [PROD_W-1:0] prod     [LANES];
  logic signed [WIDE_W-1:0] lane_sum [LANES];
  logic signed [WIDE_W-1:0] lane_acc [LANES];
  logic signed [ACC_W-1:0]  wr_data  [LANES];
  logic [LANES-1:0]         wr_en;

  assign sel_ready  = ptr_q ? i_right_ready : i_left_ready;
  assign pipe_empty = ~|{s0_vld_q, s1_vld_q};
  assign drain_hs   = (state_q == StDrain) && i_psum_ready;
  assign drain_last = drain_hs && (&drain_addr_q);

  always_comb begin
    state_d = state_q;
    consume = 1'b0;
    case (state_q)
      StIdle, StAccum: begin
        if (i_flush) begin
          state_d = StFlushWait;
        end else if (sel_ready) begin
          consume = 1'b1;
          state_d = StAccum;
        end else if (pipe_empty) begin
          state_d = StIdle;
        end
      end
      StFlushWait: if (fw_cnt_q) state_d = StDrain;
      StDrain:     if (drain_last) state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  // Acks are combinational so the buffer is released in the capture cycle.
  assign o_left_ack   = consume & ~ptr_q & i_rst_n;
  assign o_right_ack  = consume & ptr_q & i_rst_n;
  assign o_busy       = (state_q != StIdle);
  assign o_psum_valid = (state_q == StDrain);
  assign o_psum_addr  = drain_addr_q;
  assign o_psum_data  = bank_q[drain_addr_q];
  assign o_done       = done_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      ptr_q        <= 1'b0;
      fw_cnt_q     <= 1'b0;
      done_q       <= 1'b0;
      drain_addr_q <= '0;
    end else begin
      state_q  <= state_d;
      fw_cnt_q <= (state_q == StFlushWait) && !fw_cnt_q;
      done_q   <= drain_last;
      if (consume) ptr_q <= ~ptr_q;
      if (state_q != StDrain) begin
        drain_addr_q <= '0;
      end else if (drain_hs) begin
        drain_addr_q <= drain_addr_q + 1'b1;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      prod[i] = PROD_W'($signed(s0_ia_q[i])) * PROD_W'($signed(s0_w_q[i]));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s0_vld_q  <= '0;
      s0_addr_q <= '0;
      s0_ia_q   <= '0;
      s0_w_q    <= '0;
      s1_vld_q  <= '0;
      s1_addr_q <= '0;
      s1_prod_q <= '0;
    end else begin
      s0_vld_q <= consume ? (ptr_q ? i_right_lane_vld : i_left_lane_vld) : '0;
      if (consume) begin
        s0_addr_q <= ptr_q ? i_right_addr : i_left_addr;
        s0_ia_q   <= ptr_q ? i_right_ia   : i_left_ia;
        s0_w_q    <= ptr_q ? i_right_w    : i_left_w;
      end
      s1_vld_q  <= s0_vld_q;
      s1_addr_q <= s0_addr_q;
      for (int unsigned i = 0; i < LANES; i++) begin
        s1_prod_q[i] <= prod[i];
      end
    end
  end

  // Lanes sharing an address are merged; only the first such lane writes the bank.
  // The bank is read in the same cycle it is written, so back-to-back buffers see fresh data.
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_sum[i] = '0;
      wr_en[i]    = s1_vld_q[i];
      for (int unsigned j = 0; j < LANES; j++) begin
        if (s1_vld_q[j] && (s1_addr_q[j] == s1_addr_q[i])) begin
          lane_sum[i] = lane_sum[i] + WIDE_W'($signed(s1_prod_q[j]));
          if (j < i) wr_en[i] = 1'b0;
        end
      end
      lane_acc[i] = WIDE_W'(bank_q[s1_addr_q[i]]) + lane_sum[i];
      if (lane_acc[i] > ACC_MAX) begin
        wr_data[i] = ACC_MAX[ACC_W-1:0];
      end else if (lane_acc[i] < ACC_MIN) begin
        wr_data[i] = ACC_MIN[ACC_W-1:0];
      end else begin
        wr_data[i] = lane_acc[i][ACC_W-1:0];
      end
    end
  end

  // Accumulate writes and drain clears never coincide: the pipeline is empty in drain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        bank_q[k] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (wr_en[i]) bank_q[s1_addr_q[i]] <= wr_data[i];
      end
      if (drain_hs) bank_q[drain_addr_q] <= '0;
    end
  end

endmodule

// File: tb/tb_vp_psum_accumulator.sv
// Scoreboard bench for vp_psum_accumulator: directed buffers with hand-computed drain values;
// a negedge monitor pops expected beats and checks handshake-time data and stall stability.
module tb_vp_psum_accumulator;

  localparam int LANES  = 3;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 7;
  localparam int ACC_W  = 40;
  localparam int DEPTH  = 2**ADDR_W;

  typedef struct {
    int     addr;
    longint data;
  } beat_t;

  logic                    i_clk = 1'b0;
  logic                    i_rst_n = 1'b0;
  logic                    i_left_ready = 1'b0;
  logic [LANES-1:0]        i_left_lane_vld = '0;
  logic [LANES*ADDR_W-1:0] i_left_addr = '0;
  logic [LANES*DATA_W-1:0] i_left_w = '0;
  logic [LANES*DATA_W-1:0] i_left_ia = '0;
  logic                    o_left_ack;
  logic                    i_right_ready = 1'b0;
  logic [LANES-1:0]        i_right_lane_vld = '0;
  logic [LANES*ADDR_W-1:0] i_right_addr = '0;
  logic [LANES*DATA_W-1:0] i_right_w = '0;
  logic [LANES*DATA_W-1:0] i_right_ia = '0;
  logic                    o_right_ack;
  logic                    i_flush = 1'b0;
  logic                    o_busy;
  logic                    o_psum_valid;
  logic                    i_psum_ready = 1'b0;
  logic [ADDR_W-1:0]       o_psum_addr;
  logic [ACC_W-1:0]        o_psum_data;
  logic                    o_done;

  int     checks = 0;
  int     errors = 0;
  bit     bench_ptr = 1'b0;
  longint exp_bank [DEPTH];
  beat_t  exp_q [$];

  logic              stall_prev = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  longint            prev_data = 0;

  vp_psum_accumulator #(
    .LANES (LANES),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .ACC_W (ACC_W)
  ) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_left_ready    (i_left_ready),
    .i_left_lane_vld (i_left_lane_vld),
    .i_left_addr     (i_left_addr),
    .i_left_w        (i_left_w),
    .i_left_ia       (i_left_ia),
    .o_left_ack      (o_left_ack),
    .i_right_ready   (i_right_ready),
    .i_right_lane_vld(i_right_lane_vld),
    .i_right_addr    (i_right_addr),
    .i_right_w       (i_right_w),
    .i_right_ia      (i_right_ia),
    .o_right_ack     (o_right_ack),
    .i_flush         (i_flush),
    .o_busy          (o_busy),
    .o_psum_valid    (o_psum_valid),
    .i_psum_ready    (i_psum_ready),
    .o_psum_addr     (o_psum_addr),
    .o_psum_data     (o_psum_data),
    .o_done          (o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint psum_data();
    return longint'($signed(o_psum_data));
  endfunction

  // Monitor: every accepted drain beat is compared against the scoreboard queue.
  always @(negedge i_clk) begin
    beat_t b;
    if (!i_rst_n) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev && o_psum_valid) begin
        chk("hold_addr", longint'(o_psum_addr), longint'(prev_addr));
        chk("hold_data", psum_data(), prev_data);
      end
      if (o_psum_valid && i_psum_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: got addr %0d data %0d, expected no beat",
                   o_psum_addr, psum_data());
        end else begin
          b = exp_q.pop_front();
          chk("beat_addr", longint'(o_psum_addr), longint'(b.addr));
          chk("beat_data", psum_data(), b.data);
        end
      end
      stall_prev <= o_psum_valid && !i_psum_ready;
      prev_addr  <= o_psum_addr;
      prev_data  <= psum_data();
    end
  end

  // Offer one buffer on the side the bench expects the DUT to point at; check the ack.
  task automatic push_buf(input logic [2:0] vld, input logic [20:0] addr,
                          input logic [47:0] ia, input logic [47:0] w);
    if (!bench_ptr) begin
      i_left_lane_vld = vld; i_left_addr = addr; i_left_ia = ia; i_left_w = w;
      i_left_ready = 1'b1;
    end else begin
      i_right_lane_vld = vld; i_right_addr = addr; i_right_ia = ia; i_right_w = w;
      i_right_ready = 1'b1;
    end
    @(negedge i_clk);
    chk("left_ack", longint'(o_left_ack), longint'(!bench_ptr));
    chk("right_ack", longint'(o_right_ack), longint'(bench_ptr));
    @(posedge i_clk); #1;
    if (!bench_ptr) i_left_ready = 1'b0;
    else i_right_ready = 1'b0;
    bench_ptr = !bench_ptr;
  endtask

  task automatic do_flush(input bit stall);
    bit       got_done = 1'b0;
    bit [3:0] pat = 4'b1001;
    int       k = 0;
    beat_t    b;
    for (int a = 0; a < DEPTH; a++) begin
      b.addr = a;
      b.data = exp_bank[a];
      exp_q.push_back(b);
      exp_bank[a] = 0;
    end
    i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    @(negedge i_clk);
    chk("busy_after_flush", longint'(o_busy), 1);
    @(posedge i_clk); #1;
    while (!got_done && k < 2000) begin
      i_psum_ready = stall ? pat[k % 4] : 1'b1;
      @(negedge i_clk);
      if (o_done) got_done = 1'b1;
      @(posedge i_clk); #1;
      k++;
    end
    i_psum_ready = 1'b0;
    chk("done_seen", longint'(got_done), 1);
    chk("beats_missing", longint'(exp_q.size()), 0);
    @(negedge i_clk);
    chk("done_pulse", longint'(o_done), 0);
    chk("idle_after_drain", longint'(o_busy), 0);
    chk("valid_after_drain", longint'(o_psum_valid), 0);
    @(posedge i_clk); #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_left_ack"}, longint'(o_left_ack), 0);
    chk({tag, "_right_ack"}, longint'(o_right_ack), 0);
    chk({tag, "_busy"}, longint'(o_busy), 0);
    chk({tag, "_valid"}, longint'(o_psum_valid), 0);
    chk({tag, "_addr"}, longint'(o_psum_addr), 0);
    chk({tag, "_data"}, psum_data(), 0);
    chk({tag, "_done"}, longint'(o_done), 0);
  endtask

  initial begin
    bit found;
    for (int a = 0; a < DEPTH; a++) exp_bank[a] = 0;

    repeat (3) @(posedge i_clk);
    #1;
    chk_outputs_zero("reset");
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Right-only after reset: pointer is LEFT, so nothing is consumed.
    i_right_lane_vld = 3'b001; i_right_addr = {7'd0, 7'd0, 7'd21};
    i_right_ia = {16'sd0, 16'sd0, -16'sd5}; i_right_w = {16'sd0, 16'sd0, 16'sd5};
    i_right_ready = 1'b1;
    repeat (3) begin
      @(negedge i_clk);
      chk("right_only_left_ack", longint'(o_left_ack), 0);
      chk("right_only_right_ack", longint'(o_right_ack), 0);
      chk("right_only_busy", longint'(o_busy), 0);
      @(posedge i_clk); #1;
    end
    // Both ready: left first, right the following cycle.
    i_left_lane_vld = 3'b001; i_left_addr = {7'd0, 7'd0, 7'd20};
    i_left_ia = {16'sd0, 16'sd0, 16'sd2}; i_left_w = {16'sd0, 16'sd0, 16'sd3};
    i_left_ready = 1'b1;
    @(negedge i_clk);
    chk("both_left_ack", longint'(o_left_ack), 1);
    chk("both_right_ack", longint'(o_right_ack), 0);
    @(posedge i_clk); #1;
    i_left_ready = 1'b0;
    @(negedge i_clk);
    chk("next_left_ack", longint'(o_left_ack), 0);
    chk("next_right_ack", longint'(o_right_ack), 1);
    @(posedge i_clk); #1;
    i_right_ready = 1'b0;
    exp_bank[20] = 6;
    exp_bank[21] = -25;
    do_flush(1'b0);

    // Three lanes to distinct addresses.
    push_buf(3'b111, {7'd7, 7'd6, 7'd5}, {16'sd100, -16'sd2, 16'sd3},
             {16'sd100, 16'sd7, 16'sd4});
    exp_bank[5] = 12;
    exp_bank[6] = -14;
    exp_bank[7] = 10000;
    do_flush(1'b0);

    // Same-address lanes combined, then a back-to-back buffer to that address;
    // invalid lanes of the second buffer must contribute nothing.
    push_buf(3'b111, {7'd9, 7'd9, 7'd9}, {-16'sd1, 16'sd4, 16'sd2}, {16'sd1, 16'sd5, 16'sd3});
    push_buf(3'b001, {7'd9, 7'd9, 7'd9}, {16'sd7, 16'sd7, 16'sd10}, {16'sd7, 16'sd7, 16'sd10});
    exp_bank[9] = 125;
    do_flush(1'b0);

    // Saturation: 540 products of ~2**30 overrun both ends of the 40-bit range.
    for (int n = 0; n < 180; n++) begin
      push_buf(3'b111, {3{7'd0}}, {3{16'sd32767}}, {3{16'sd32767}});
    end
    for (int n = 0; n < 180; n++) begin
      push_buf(3'b111, {3{7'd1}}, {3{16'h8000}}, {3{16'sd32767}});
    end
    exp_bank[0] = 64'sd549755813887;
    exp_bank[1] = -64'sd549755813888;
    do_flush(1'b0);

    // Stalled drain, then a second flush that must return all zeros.
    push_buf(3'b011, {7'd0, 7'd127, 7'd3}, {16'sd0, -16'sd3, 16'sd11},
             {16'sd0, 16'sd3, 16'sd11});
    exp_bank[3] = 121;
    exp_bank[127] = -9;
    do_flush(1'b1);
    do_flush(1'b0);

    // Reset in the middle of a drain.
    push_buf(3'b001, {7'd0, 7'd0, 7'd50}, {16'sd0, 16'sd0, 16'sd7}, {16'sd0, 16'sd0, 16'sd7});
    exp_bank[50] = 0;
    for (int a = 0; a < DEPTH; a++) begin
      beat_t b;
      b.addr = a;
      b.data = (a == 50) ? 49 : 0;
      exp_q.push_back(b);
    end
    i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    i_psum_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge i_clk);
      if (o_psum_valid && o_psum_addr == 7'd40) found = 1'b1;
    end
    chk("reached_addr40", longint'(found), 1);
    #1;
    i_rst_n = 1'b0;
    i_psum_ready = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    exp_q.delete();
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    bench_ptr = 1'b0;
    @(posedge i_clk); #1;
    do_flush(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
